// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 16;

  function automatic logic [MAX_DIGITS-1:0] onehot(input int index);
    return MAX_DIGITS'(1) << index;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Bundles the control and display-side signals of seg7_scan_ctrl.
interface seg7_scan_ctrl_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) ();

  // load is a single-cycle strobe with no back-pressure: the value on the
  // load cycle is always accepted, and a later load before the frame
  // boundary replaces it.
  logic                           enable;
  logic                           load;
  logic [NIBBLE_W*NUM_DIGITS-1:0] value;
  logic                           lz_suppress;
  logic [NIBBLE_W-1:0]            nibble;
  logic [NUM_DIGITS-1:0]          digit_en;
  logic                           frame_done;
  logic                           pending;

  modport master (
    output enable, load, value, lz_suppress,
    input  nibble, digit_en, frame_done, pending
  );

  modport slave (
    input  enable, load, value, lz_suppress,
    output nibble, digit_en, frame_done, pending
  );

endinterface

// File: rtl/seg7_lz_mask.sv
// Leading-zero suppress mask: digit k is blanked when it and every digit above it are zero.
module seg7_lz_mask
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] i_Value,
  input  logic                           i_LZ_Suppress,
  output logic [NUM_DIGITS-1:0]          o_Mask
);

  logic w_zero_above;

  // Digit 0 is excluded so an all-zero value still shows a single "0".
  always_comb begin
    o_Mask       = '0;
    w_zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_zero_above = w_zero_above & (i_Value[k*NIBBLE_W +: NIBBLE_W] == '0);
      o_Mask[k]    = i_LZ_Suppress & w_zero_above;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with dead-time and frame-aligned value updates.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 6250,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst_L,
  input  logic                           i_Enable,
  input  logic                           i_Load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] i_Value,
  input  logic                           i_LZ_Suppress,
  output logic [NIBBLE_W-1:0]            o_Nibble,
  output logic [NUM_DIGITS-1:0]          o_Digit_En,
  output logic                           o_Frame_Done,
  output logic                           o_Pending
);

  localparam int VAL_W   = NIBBLE_W * NUM_DIGITS;
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_BLANK = 2'(BLANK);
  localparam logic [1:0] ST_SHOW  = 2'(SHOW);

  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic [VAL_W-1:0]      r_active;
  logic [VAL_W-1:0]      r_shadow;
  logic                  r_pending;
  logic [NIBBLE_W-1:0]   r_nibble;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic                  r_frame_done;

  logic [1:0]            w_state_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_commit;
  logic [VAL_W-1:0]      w_active_nxt;
  logic [NIBBLE_W-1:0]   w_nib_sel;
  logic [NUM_DIGITS-1:0] w_digit_sel;
  logic [NUM_DIGITS-1:0] w_lz_mask;

  seg7_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask (
    .i_Value       (r_active),
    .i_LZ_Suppress (i_LZ_Suppress),
    .o_Mask        (w_lz_mask)
  );

  assign w_commit = (r_state == ST_SHOW) && (r_cnt == SHOW_LAST) &&
                    (r_idx == IDX_LAST) && i_Enable;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_Enable) begin
          w_state_nxt = ST_BLANK;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
    // Dropping enable aborts the frame from any state without committing.
    if (!i_Enable) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end
  end

  // A load that lands on the commit cycle bypasses the shadow entirely.
  always_comb begin
    w_active_nxt = r_active;
    if (i_Load && ((r_state == ST_IDLE) || w_commit))
      w_active_nxt = i_Value;
    else if (w_commit && r_pending)
      w_active_nxt = r_shadow;
  end

  always_comb begin
    w_nib_sel = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_idx_nxt == IDX_W'(k))
        w_nib_sel = w_active_nxt[k*NIBBLE_W +: NIBBLE_W];
    end
  end

  assign w_digit_sel = NUM_DIGITS'(onehot(int'(w_idx_nxt)));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_active     <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_nibble     <= '0;
      r_digit_en   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_active     <= w_active_nxt;
      r_frame_done <= w_commit;

      if (i_Load && (r_state != ST_IDLE) && !w_commit)
        r_shadow <= i_Value;

      if ((i_Load && (r_state == ST_IDLE)) || w_commit)
        r_pending <= 1'b0;
      else if (i_Load)
        r_pending <= 1'b1;

      // Nibble is set up on entry to BLANK so the decoder output settles before SHOW.
      if (w_state_nxt == ST_BLANK)
        r_nibble <= w_nib_sel;

      if (w_state_nxt == ST_SHOW)
        r_digit_en <= w_digit_sel & ~w_lz_mask;
      else
        r_digit_en <= '0;
    end
  end

  assign o_Nibble     = r_nibble;
  assign o_Digit_En   = r_digit_en;
  assign o_Frame_Done = r_frame_done;
  assign o_Pending    = r_pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int DC = BC + RD;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Enable      (bus.enable),
    .i_Load        (bus.load),
    .i_Value       (bus.value),
    .i_LZ_Suppress (bus.lz_suppress),
    .o_Nibble      (bus.nibble),
    .o_Digit_En    (bus.digit_en),
    .o_Frame_Done  (bus.frame_done),
    .o_Pending     (bus.pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_value(input logic [15:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  // Walks one 40-cycle frame starting at its first BLANK cycle, with optional loads
  // at cycle la/lb and an optional enable drop at cycle drop_at.
  task automatic check_frame(input logic [3:0] lit, input logic fd_first,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input int drop_at, input string tag);
    logic [15:0] nibs;
    logic [3:0]  exp_en;
    logic        p;
    logic        did_load;
    int          cyc;
    nibs = exp_q.pop_front();
    p    = 1'b0;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < DC; c++) begin
        cyc    = d * DC + c;
        exp_en = (c >= BC && lit[d]) ? 4'(1 << d) : 4'b0000;
        check($sformatf("%s d%0d c%0d en", tag, d, c), 32'(bus.digit_en), 32'(exp_en));
        check($sformatf("%s d%0d c%0d nib", tag, d, c), 32'(bus.nibble), 32'(nibs[d*4 +: 4]));
        check($sformatf("%s d%0d c%0d fd", tag, d, c), 32'(bus.frame_done),
              32'((cyc == 0) ? fd_first : 1'b0));
        check($sformatf("%s d%0d c%0d pend", tag, d, c), 32'(bus.pending), 32'(p));
        if (cyc == drop_at) begin
          bus.enable = 1'b0;
          tick();
          check($sformatf("%s drop en", tag), 32'(bus.digit_en), 32'h0);
          check($sformatf("%s drop fd", tag), 32'(bus.frame_done), 32'h0);
          return;
        end
        did_load = 1'b0;
        if (cyc == la) begin
          bus.value = va;
          bus.load  = 1'b1;
          did_load  = 1'b1;
        end
        if (cyc == lb) begin
          bus.value = vb;
          bus.load  = 1'b1;
          did_load  = 1'b1;
        end
        tick();
        bus.load = 1'b0;
        if (did_load && cyc != ND * DC - 1) p = 1'b1;
      end
    end
  endtask

  initial begin
    bus.enable      = 1'b0;
    bus.load        = 1'b0;
    bus.value       = '0;
    bus.lz_suppress = 1'b0;
    rst_n           = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("reset nib", 32'(bus.nibble), 32'h0);
    check("reset en", 32'(bus.digit_en), 32'h0);
    check("reset fd", 32'(bus.frame_done), 32'h0);
    check("reset pend", 32'(bus.pending), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    load_value(16'h1234);
    check("idle load pend", 32'(bus.pending), 32'h0);
    check("idle load en", 32'(bus.digit_en), 32'h0);
    check("idle load nib", 32'(bus.nibble), 32'h0);

    bus.enable = 1'b1;
    tick();
    exp_q.push_back(16'h1234);
    check_frame(4'hF, 1'b0, -1, 16'h0, -1, 16'h0, -1, "scan");
    exp_q.push_back(16'h1234);
    check_frame(4'hF, 1'b1, 12, 16'hABCD, -1, 16'h0, -1, "defer");
    exp_q.push_back(16'hABCD);
    check_frame(4'hF, 1'b1, -1, 16'h0, -1, 16'h0, -1, "defer_new");
    exp_q.push_back(16'hABCD);
    check_frame(4'hF, 1'b1, 5, 16'h1111, 25, 16'h2222, -1, "last_wins");
    exp_q.push_back(16'h2222);
    check_frame(4'hF, 1'b1, 39, 16'h3333, -1, 16'h0, -1, "commit_load");
    exp_q.push_back(16'h3333);
    check_frame(4'hF, 1'b1, -1, 16'h0, -1, 16'h0, -1, "commit_show");

    exp_q.push_back(16'h3333);
    check_frame(4'hF, 1'b1, -1, 16'h0, -1, 16'h0, 25, "drop");
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("disabled %0d en", i), 32'(bus.digit_en), 32'h0);
      check($sformatf("disabled %0d fd", i), 32'(bus.frame_done), 32'h0);
    end

    bus.enable = 1'b1;
    tick();
    bus.lz_suppress = 1'b1;
    exp_q.push_back(16'h3333);
    check_frame(4'hF, 1'b0, 10, 16'h0050, -1, 16'h0, -1, "reenable");
    exp_q.push_back(16'h0050);
    check_frame(4'b0011, 1'b1, 10, 16'h0000, -1, 16'h0, -1, "lz_0050");
    exp_q.push_back(16'h0000);
    check_frame(4'b0001, 1'b1, 10, 16'h1234, -1, 16'h0, -1, "lz_0000");

    repeat (4) tick();
    check("pre_rst en", 32'(bus.digit_en), 32'h1);
    check("pre_rst nib", 32'(bus.nibble), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst en", 32'(bus.digit_en), 32'h0);
    check("async_rst nib", 32'(bus.nibble), 32'h0);
    check("async_rst fd", 32'(bus.frame_done), 32'h0);
    check("async_rst pend", 32'(bus.pending), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_q.push_back(16'h0000);
    check_frame(4'b0001, 1'b0, -1, 16'h0, -1, 16'h0, -1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-cathode 7-segment display.
It shares one registered hex-to-7-segment decoder across NUM_DIGITS digits.
Each cycle it presents one nibble to the decoder and drives a one-hot digit enable.
It inserts dead-time between digits to suppress ghosting, and applies new display values only at frame boundaries so a frame never mixes old and new values.

Parameters:
NUM_DIGITS, 4, number of digits scanned; each digit is 4 bits of i_Value.
REFRESH_DIV, 6250, clock cycles each digit stays lit (SHOW phase); minimum 2.
BLANK_CYCLES, 64, clock cycles all digits are off before each digit lights; minimum 2, which covers the decoder's 1-cycle registered latency.

Ports:
i_Clk  input  1  system clock; all logic on rising edge.
i_Rst_L  input  1  asynchronous active-low reset.
i_Enable  input  1  1 = scanning runs; 0 = all digits off.
i_Load  input  1  single-cycle strobe; captures i_Value.
i_Value  input  4*NUM_DIGITS  display value; nibble 0 (bits 3:0) is the least significant digit.
i_LZ_Suppress  input  1  1 = blank leading zero digits.
o_Nibble  output  4  nibble sent to the shared decoder.
o_Digit_En  output  NUM_DIGITS  active-high one-hot digit select.
o_Frame_Done  output  1  1-cycle pulse at the end of the last digit's SHOW phase.
o_Pending  output  1  a loaded value is waiting for a frame boundary.

Behaviour:
- Reset (async, i_Rst_L=0):
  - state=IDLE, digit index=0, phase counter=0.
  - active value=0, shadow value=0, pending=0.
  - o_Nibble=0, o_Digit_En=0, o_Frame_Done=0, o_Pending=0.
  - All outputs are registered.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - o_Digit_En=0.
  - i_Enable=1 -> BLANK, with index=0 and counter=0.
  - i_Load in IDLE writes i_Value straight to active; pending stays 0.
- BLANK:
  - o_Digit_En=0.
  - o_Nibble=active nibble[index].
  - Lasts exactly BLANK_CYCLES cycles, then -> SHOW with counter=0.
- SHOW:
  - o_Digit_En = 1<<index, unless the digit is suppressed, in which case 0.
  - o_Nibble is held.
  - Lasts exactly REFRESH_DIV cycles. On the last cycle:
    - index<NUM_DIGITS-1: index+1, -> BLANK.
    - index==NUM_DIGITS-1: index=0, pulse o_Frame_Done on the next cycle, commit the frame, -> BLANK.
- Frame commit: if pending, active <= shadow and pending <= 0.
- Load outside IDLE:
  - shadow <= i_Value, pending <= 1.
  - A later load before the commit overwrites shadow (last wins).
  - Load in the same cycle as a commit: active <= i_Value directly; pending ends at 0.
- Leading-zero suppression, when i_LZ_Suppress=1:
  - Digit k is suppressed if nibbles NUM_DIGITS-1..k of active are all 0.
  - Digit 0 is never suppressed, so value 0 shows "0".
  - Evaluated on the active value only.
- i_Enable falling in any state:
  - Next cycle: state=IDLE, o_Digit_En=0, index=0, counter=0.
  - No o_Frame_Done pulse; active, shadow and pending are retained.
- Counter width is $clog2(max(REFRESH_DIV, BLANK_CYCLES)); it wraps only through the explicit terminal compare.
- Full frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- o_Pending mirrors the pending flag.

Decomposition:
- Package seg7_pkg holds:
  - enum scan_state_t {IDLE, BLANK, SHOW};
  - localparam NIBBLE_W=4;
  - function onehot(index).
- One sub-module, seg7_lz_mask: combinational. Takes the active value and i_LZ_Suppress; outputs a NUM_DIGITS suppress mask.
- The decoder is instantiated externally and driven by o_Nibble. It is not part of this block.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Scan sequence. Reset, load 16'h1234 in IDLE, then i_Enable=1 -> o_Digit_En sequence 0000(2 cycles), 0001(8), 0000(2), 0010(8), ... with o_Nibble 4,3,2,1. o_Frame_Done pulses once every 40 cycles.
- Deferred load. Active=16'h1234 mid-frame; load 16'hABCD at digit 1 -> o_Pending=1 and digits 2 and 3 still show 2,1. After o_Frame_Done, o_Pending=0 and the next frame shows D,C,B,A.
- Load collisions. Load 16'h1111 then 16'h2222 in the same frame -> next frame shows 2222. Separately, a load coincident with the commit cycle -> that value shows next frame and o_Pending=0.
- Leading-zero suppression. i_LZ_Suppress=1 with value 16'h0050 -> digits 3 and 2 have enable 0 in SHOW; digits 1 and 0 light with 5 and 0. With value 16'h0000 -> only digit 0 lights.
- Enable drop. Drop i_Enable during digit 2 SHOW -> o_Digit_En=0 next cycle and no o_Frame_Done. Re-enable -> restart at BLANK, digit 0.
- Reset mid-SHOW. Assert i_Rst_L=0 asynchronously -> o_Digit_En=0 and o_Nibble=0 immediately without waiting for a clock edge. After release, the active value is 0.
